aes_inv_sub_bytes: RTL and testbench



---
 rtl/aes_inv_sub_bytes_pkg.sv | 20 ++
 rtl/aes_inv_sub_bytes_inv_sbox.sv | 49 ++++
 rtl/aes_inv_sub_bytes.sv | 106 ++++++++++
 tb/tb_aes_inv_sub_bytes.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_inv_sub_bytes_pkg.sv
// Shared AES definitions: state/byte widths, byte addressing and engine FSM states.
package aes_inv_sub_bytes_pkg;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_BYTE_W  = 8;
    localparam int unsigned AES_NBYTES  = AES_STATE_W / AES_BYTE_W;
    localparam int unsigned AES_IDX_W   = $clog2(AES_STATE_W);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } fsm_e;

    // Bit position of the MSB of byte k; byte 0 sits at the top of the state word
    function automatic int unsigned byte_msb(input int unsigned k);
        return AES_STATE_W - 1 - AES_BYTE_W * k;
    endfunction

endpackage

// File: rtl/aes_inv_sub_bytes_inv_sbox.sv
// Combinational AES inverse S-box lookup, one byte in, one byte out.
module aes_inv_sub_bytes_inv_sbox
    import aes_inv_sub_bytes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] i_byte,
    output logic [AES_BYTE_W-1:0] o_byte_c
);

    // Inverse substitution table, row = high nibble
    always_comb begin
        o_byte_c = 8'h00;
        case (i_byte)
            8'h00: o_byte_c = 8'h52; 8'h01: o_byte_c = 8'h09; 8'h02: o_byte_c = 8'h6a; 8'h03: o_byte_c = 8'hd5; 8'h04: o_byte_c = 8'h30; 8'h05: o_byte_c = 8'h36; 8'h06: o_byte_c = 8'ha5; 8'h07: o_byte_c = 8'h38;
            8'h08: o_byte_c = 8'hbf; 8'h09: o_byte_c = 8'h40; 8'h0a: o_byte_c = 8'ha3; 8'h0b: o_byte_c = 8'h9e; 8'h0c: o_byte_c = 8'h81; 8'h0d: o_byte_c = 8'hf3; 8'h0e: o_byte_c = 8'hd7; 8'h0f: o_byte_c = 8'hfb;
            8'h10: o_byte_c = 8'h7c; 8'h11: o_byte_c = 8'he3; 8'h12: o_byte_c = 8'h39; 8'h13: o_byte_c = 8'h82; 8'h14: o_byte_c = 8'h9b; 8'h15: o_byte_c = 8'h2f; 8'h16: o_byte_c = 8'hff; 8'h17: o_byte_c = 8'h87;
            8'h18: o_byte_c = 8'h34; 8'h19: o_byte_c = 8'h8e; 8'h1a: o_byte_c = 8'h43; 8'h1b: o_byte_c = 8'h44; 8'h1c: o_byte_c = 8'hc4; 8'h1d: o_byte_c = 8'hde; 8'h1e: o_byte_c = 8'he9; 8'h1f: o_byte_c = 8'hcb;
            8'h20: o_byte_c = 8'h54; 8'h21: o_byte_c = 8'h7b; 8'h22: o_byte_c = 8'h94; 8'h23: o_byte_c = 8'h32; 8'h24: o_byte_c = 8'ha6; 8'h25: o_byte_c = 8'hc2; 8'h26: o_byte_c = 8'h23; 8'h27: o_byte_c = 8'h3d;
            8'h28: o_byte_c = 8'hee; 8'h29: o_byte_c = 8'h4c; 8'h2a: o_byte_c = 8'h95; 8'h2b: o_byte_c = 8'h0b; 8'h2c: o_byte_c = 8'h42; 8'h2d: o_byte_c = 8'hfa; 8'h2e: o_byte_c = 8'hc3; 8'h2f: o_byte_c = 8'h4e;
            8'h30: o_byte_c = 8'h08; 8'h31: o_byte_c = 8'h2e; 8'h32: o_byte_c = 8'ha1; 8'h33: o_byte_c = 8'h66; 8'h34: o_byte_c = 8'h28; 8'h35: o_byte_c = 8'hd9; 8'h36: o_byte_c = 8'h24; 8'h37: o_byte_c = 8'hb2;
            8'h38: o_byte_c = 8'h76; 8'h39: o_byte_c = 8'h5b; 8'h3a: o_byte_c = 8'ha2; 8'h3b: o_byte_c = 8'h49; 8'h3c: o_byte_c = 8'h6d; 8'h3d: o_byte_c = 8'h8b; 8'h3e: o_byte_c = 8'hd1; 8'h3f: o_byte_c = 8'h25;
            8'h40: o_byte_c = 8'h72; 8'h41: o_byte_c = 8'hf8; 8'h42: o_byte_c = 8'hf6; 8'h43: o_byte_c = 8'h64; 8'h44: o_byte_c = 8'h86; 8'h45: o_byte_c = 8'h68; 8'h46: o_byte_c = 8'h98; 8'h47: o_byte_c = 8'h16;
            8'h48: o_byte_c = 8'hd4; 8'h49: o_byte_c = 8'ha4; 8'h4a: o_byte_c = 8'h5c; 8'h4b: o_byte_c = 8'hcc; 8'h4c: o_byte_c = 8'h5d; 8'h4d: o_byte_c = 8'h65; 8'h4e: o_byte_c = 8'hb6; 8'h4f: o_byte_c = 8'h92;
            8'h50: o_byte_c = 8'h6c; 8'h51: o_byte_c = 8'h70; 8'h52: o_byte_c = 8'h48; 8'h53: o_byte_c = 8'h50; 8'h54: o_byte_c = 8'hfd; 8'h55: o_byte_c = 8'hed; 8'h56: o_byte_c = 8'hb9; 8'h57: o_byte_c = 8'hda;
            8'h58: o_byte_c = 8'h5e; 8'h59: o_byte_c = 8'h15; 8'h5a: o_byte_c = 8'h46; 8'h5b: o_byte_c = 8'h57; 8'h5c: o_byte_c = 8'ha7; 8'h5d: o_byte_c = 8'h8d; 8'h5e: o_byte_c = 8'h9d; 8'h5f: o_byte_c = 8'h84;
            8'h60: o_byte_c = 8'h90; 8'h61: o_byte_c = 8'hd8; 8'h62: o_byte_c = 8'hab; 8'h63: o_byte_c = 8'h00; 8'h64: o_byte_c = 8'h8c; 8'h65: o_byte_c = 8'hbc; 8'h66: o_byte_c = 8'hd3; 8'h67: o_byte_c = 8'h0a;
            8'h68: o_byte_c = 8'hf7; 8'h69: o_byte_c = 8'he4; 8'h6a: o_byte_c = 8'h58; 8'h6b: o_byte_c = 8'h05; 8'h6c: o_byte_c = 8'hb8; 8'h6d: o_byte_c = 8'hb3; 8'h6e: o_byte_c = 8'h45; 8'h6f: o_byte_c = 8'h06;
            8'h70: o_byte_c = 8'hd0; 8'h71: o_byte_c = 8'h2c; 8'h72: o_byte_c = 8'h1e; 8'h73: o_byte_c = 8'h8f; 8'h74: o_byte_c = 8'hca; 8'h75: o_byte_c = 8'h3f; 8'h76: o_byte_c = 8'h0f; 8'h77: o_byte_c = 8'h02;
            8'h78: o_byte_c = 8'hc1; 8'h79: o_byte_c = 8'haf; 8'h7a: o_byte_c = 8'hbd; 8'h7b: o_byte_c = 8'h03; 8'h7c: o_byte_c = 8'h01; 8'h7d: o_byte_c = 8'h13; 8'h7e: o_byte_c = 8'h8a; 8'h7f: o_byte_c = 8'h6b;
            8'h80: o_byte_c = 8'h3a; 8'h81: o_byte_c = 8'h91; 8'h82: o_byte_c = 8'h11; 8'h83: o_byte_c = 8'h41; 8'h84: o_byte_c = 8'h4f; 8'h85: o_byte_c = 8'h67; 8'h86: o_byte_c = 8'hdc; 8'h87: o_byte_c = 8'hea;
            8'h88: o_byte_c = 8'h97; 8'h89: o_byte_c = 8'hf2; 8'h8a: o_byte_c = 8'hcf; 8'h8b: o_byte_c = 8'hce; 8'h8c: o_byte_c = 8'hf0; 8'h8d: o_byte_c = 8'hb4; 8'h8e: o_byte_c = 8'he6; 8'h8f: o_byte_c = 8'h73;
            8'h90: o_byte_c = 8'h96; 8'h91: o_byte_c = 8'hac; 8'h92: o_byte_c = 8'h74; 8'h93: o_byte_c = 8'h22; 8'h94: o_byte_c = 8'he7; 8'h95: o_byte_c = 8'had; 8'h96: o_byte_c = 8'h35; 8'h97: o_byte_c = 8'h85;
            8'h98: o_byte_c = 8'he2; 8'h99: o_byte_c = 8'hf9; 8'h9a: o_byte_c = 8'h37; 8'h9b: o_byte_c = 8'he8; 8'h9c: o_byte_c = 8'h1c; 8'h9d: o_byte_c = 8'h75; 8'h9e: o_byte_c = 8'hdf; 8'h9f: o_byte_c = 8'h6e;
            8'ha0: o_byte_c = 8'h47; 8'ha1: o_byte_c = 8'hf1; 8'ha2: o_byte_c = 8'h1a; 8'ha3: o_byte_c = 8'h71; 8'ha4: o_byte_c = 8'h1d; 8'ha5: o_byte_c = 8'h29; 8'ha6: o_byte_c = 8'hc5; 8'ha7: o_byte_c = 8'h89;
            8'ha8: o_byte_c = 8'h6f; 8'ha9: o_byte_c = 8'hb7; 8'haa: o_byte_c = 8'h62; 8'hab: o_byte_c = 8'h0e; 8'hac: o_byte_c = 8'haa; 8'had: o_byte_c = 8'h18; 8'hae: o_byte_c = 8'hbe; 8'haf: o_byte_c = 8'h1b;
            8'hb0: o_byte_c = 8'hfc; 8'hb1: o_byte_c = 8'h56; 8'hb2: o_byte_c = 8'h3e; 8'hb3: o_byte_c = 8'h4b; 8'hb4: o_byte_c = 8'hc6; 8'hb5: o_byte_c = 8'hd2; 8'hb6: o_byte_c = 8'h79; 8'hb7: o_byte_c = 8'h20;
            8'hb8: o_byte_c = 8'h9a; 8'hb9: o_byte_c = 8'hdb; 8'hba: o_byte_c = 8'hc0; 8'hbb: o_byte_c = 8'hfe; 8'hbc: o_byte_c = 8'h78; 8'hbd: o_byte_c = 8'hcd; 8'hbe: o_byte_c = 8'h5a; 8'hbf: o_byte_c = 8'hf4;
            8'hc0: o_byte_c = 8'h1f; 8'hc1: o_byte_c = 8'hdd; 8'hc2: o_byte_c = 8'ha8; 8'hc3: o_byte_c = 8'h33; 8'hc4: o_byte_c = 8'h88; 8'hc5: o_byte_c = 8'h07; 8'hc6: o_byte_c = 8'hc7; 8'hc7: o_byte_c = 8'h31;
            8'hc8: o_byte_c = 8'hb1; 8'hc9: o_byte_c = 8'h12; 8'hca: o_byte_c = 8'h10; 8'hcb: o_byte_c = 8'h59; 8'hcc: o_byte_c = 8'h27; 8'hcd: o_byte_c = 8'h80; 8'hce: o_byte_c = 8'hec; 8'hcf: o_byte_c = 8'h5f;
            8'hd0: o_byte_c = 8'h60; 8'hd1: o_byte_c = 8'h51; 8'hd2: o_byte_c = 8'h7f; 8'hd3: o_byte_c = 8'ha9; 8'hd4: o_byte_c = 8'h19; 8'hd5: o_byte_c = 8'hb5; 8'hd6: o_byte_c = 8'h4a; 8'hd7: o_byte_c = 8'h0d;
            8'hd8: o_byte_c = 8'h2d; 8'hd9: o_byte_c = 8'he5; 8'hda: o_byte_c = 8'h7a; 8'hdb: o_byte_c = 8'h9f; 8'hdc: o_byte_c = 8'h93; 8'hdd: o_byte_c = 8'hc9; 8'hde: o_byte_c = 8'h9c; 8'hdf: o_byte_c = 8'hef;
            8'he0: o_byte_c = 8'ha0; 8'he1: o_byte_c = 8'he0; 8'he2: o_byte_c = 8'h3b; 8'he3: o_byte_c = 8'h4d; 8'he4: o_byte_c = 8'hae; 8'he5: o_byte_c = 8'h2a; 8'he6: o_byte_c = 8'hf5; 8'he7: o_byte_c = 8'hb0;
            8'he8: o_byte_c = 8'hc8; 8'he9: o_byte_c = 8'heb; 8'hea: o_byte_c = 8'hbb; 8'heb: o_byte_c = 8'h3c; 8'hec: o_byte_c = 8'h83; 8'hed: o_byte_c = 8'h53; 8'hee: o_byte_c = 8'h99; 8'hef: o_byte_c = 8'h61;
            8'hf0: o_byte_c = 8'h17; 8'hf1: o_byte_c = 8'h2b; 8'hf2: o_byte_c = 8'h04; 8'hf3: o_byte_c = 8'h7e; 8'hf4: o_byte_c = 8'hba; 8'hf5: o_byte_c = 8'h77; 8'hf6: o_byte_c = 8'hd6; 8'hf7: o_byte_c = 8'h26;
            8'hf8: o_byte_c = 8'he1; 8'hf9: o_byte_c = 8'h69; 8'hfa: o_byte_c = 8'h14; 8'hfb: o_byte_c = 8'h63; 8'hfc: o_byte_c = 8'h55; 8'hfd: o_byte_c = 8'h21; 8'hfe: o_byte_c = 8'h0c; 8'hff: o_byte_c = 8'h7d;
            default: o_byte_c = 8'h00;
        endcase
    end

endmodule

// File: rtl/aes_inv_sub_bytes.sv
// Sequential AES InvSubBytes: captures a state, substitutes BPC bytes per cycle, hands it back.
module aes_inv_sub_bytes
    import aes_inv_sub_bytes_pkg::*;
#(
    parameter int unsigned BPC = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [AES_STATE_W-1:0] i_state_in,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [AES_STATE_W-1:0] o_state_out
);

    localparam int unsigned NCYC  = AES_NBYTES / BPC;
    localparam int unsigned CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;

    if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 || BPC == 16)) begin : g_bad_bpc
        $error("aes_inv_sub_bytes: BPC must be 1, 2, 4, 8 or 16");
    end

    fsm_e                   r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [AES_STATE_W-1:0] r_work;
    logic                   r_in_ready;
    logic                   r_out_valid;

    logic [AES_BYTE_W-1:0]  w_sel [BPC];
    logic [AES_BYTE_W-1:0]  w_sub [BPC];
    logic [AES_STATE_W-1:0] w_work_sub;
    logic                   w_last;

    assign w_last = (r_cnt == CNT_W'(NCYC - 1));

    // Select the slice of bytes addressed by the counter
    always_comb begin
        w_sel = '{default: '0};
        for (int unsigned b = 0; b < BPC; b++) begin
            w_sel[b] = r_work[AES_IDX_W'(byte_msb(32'(r_cnt) * BPC + b)) -: AES_BYTE_W];
        end
    end

    for (genvar g = 0; g < BPC; g++) begin : g_sbox
        aes_inv_sub_bytes_inv_sbox u_inv_sbox (
            .i_byte   (w_sel[g]),
            .o_byte_c (w_sub[g])
        );
    end

    // Working word with the current slice replaced by its substituted bytes
    always_comb begin
        w_work_sub = r_work;
        for (int unsigned b = 0; b < BPC; b++) begin
            w_work_sub[AES_IDX_W'(byte_msb(32'(r_cnt) * BPC + b)) -: AES_BYTE_W] = w_sub[b];
        end
    end

    // Control FSM, byte counter and working register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_work      <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (i_in_valid && r_in_ready) begin
                        r_work     <= i_state_in;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    r_work <= w_work_sub;
                    if (w_last) begin
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Result stays put until downstream takes it; no accept this cycle
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_state_out = r_work;

endmodule

// File: tb/tb_aes_inv_sub_bytes.sv
// Self-checking bench for aes_inv_sub_bytes against a GF(2^8)-derived inverse S-box model.
module tb_aes_inv_sub_bytes;

    localparam int unsigned M_BPC  = 4;
    localparam int unsigned M_NCYC = 16 / M_BPC;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [7:0] inv_tab [256];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_inv_sub_bytes #(.BPC(M_BPC)) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_state_in  (state_in),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_state_out (state_out)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // ---------------- reference model: S-box from field inverse + affine map ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0]  b;
        logic [15:0] t;
        b = ginv(x);
        t = {b, b};
        return b ^ t[14:7] ^ t[13:6] ^ t[12:5] ^ t[11:4] ^ 8'h63;
    endfunction

    function automatic logic [127:0] inv_state(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = inv_tab[s[127-8*k -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand_blk();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- main-instance drivers ----------------
    task automatic send_blk(input logic [127:0] blk, output int lat);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        state_in = blk;
        for (int t = 0; t < 50 && !acc; t++) begin
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_blk(input logic [127:0] blk, input logic [127:0] exp, input string tag);
        int lat;
        send_blk(blk, lat);
        chk({tag, "_lat"}, 128'(lat), 128'(M_NCYC + 1));
        chk(tag, state_out, exp);
        @(posedge clk); #1;
        chk({tag, "_hs"}, {126'b0, out_valid, in_ready}, 128'b01);
    endtask

    task automatic run_backpressure();
        logic [127:0] a;
        logic [127:0] ea;
        int lat;
        a  = rand_blk();
        ea = inv_state(a);
        out_ready = 1'b0;
        send_blk(a, lat);
        chk("bp_lat", 128'(lat), 128'(M_NCYC + 1));
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            state_in = ~a;
            chk($sformatf("bp_hold%0d_vr", i), {126'b0, out_valid, in_ready}, 128'b10);
            chk($sformatf("bp_hold%0d_data", i), state_out, ea);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_vr", {126'b0, out_valid, in_ready}, 128'b01);
        chk("bp_no_capture", state_out, ea);
    endtask

    task automatic run_reset_mid();
        logic [127:0] b;
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        state_in = rand_blk();
        for (int t = 0; t < 50 && !acc; t++) begin
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_vr", {126'b0, out_valid, in_ready}, 128'b00);
        chk("rst_mid_data", state_out, 128'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_release_vr", {126'b0, out_valid, in_ready}, 128'b01);
        b = rand_blk();
        run_blk(b, inv_state(b), "post_rst");
    endtask

    task automatic run_stream();
        logic [127:0] sblk [4];
        int acc_cyc [4];
        int extra;
        for (int i = 0; i < 4; i++) sblk[i] = rand_blk();
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    bit acc;
                    acc      = 1'b0;
                    state_in = sblk[i];
                    in_valid = 1'b1;
                    for (int t = 0; t < 50 && !acc; t++) begin
                        acc = in_ready;
                        @(posedge clk); #1;
                    end
                    acc_cyc[i] = cyc;
                end
                in_valid = 1'b0;
            end
            begin
                for (int j = 0; j < 4; j++) begin
                    int w;
                    w = 0;
                    while (!out_valid && w < 60) begin
                        @(posedge clk); #1;
                        w++;
                    end
                    chk($sformatf("stream_blk%0d", j), state_out, inv_state(sblk[j]));
                    @(posedge clk); #1;
                end
            end
        join
        for (int i = 1; i < 4; i++)
            chk($sformatf("stream_gap%0d", i), 128'(acc_cyc[i] - acc_cyc[i-1]), 128'(M_NCYC + 2));
        extra = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        chk("stream_no_dup", 128'(extra), 128'h0);
    endtask

    // ---------------- round trip over every S-box output, one instance per BPC ----------------
    for (genvar g = 0; g < 5; g++) begin : g_rt
        localparam int unsigned P = 1 << g;
        localparam int unsigned N = 16 / P;
        logic         rt_rst;
        logic         iv;
        logic         ir;
        logic         ov;
        logic [127:0] si;
        logic [127:0] so;
        logic         done;

        aes_inv_sub_bytes #(.BPC(P)) u_rt (
            .i_clk       (clk),
            .i_rst       (rt_rst),
            .i_in_valid  (iv),
            .o_in_ready  (ir),
            .i_state_in  (si),
            .o_out_valid (ov),
            .i_out_ready (1'b1),
            .o_state_out (so)
        );

        initial begin
            logic [127:0] blk;
            logic [127:0] exp;
            int lat;
            bit acc;
            done   = 1'b0;
            rt_rst = 1'b1;
            iv     = 1'b0;
            si     = '0;
            repeat (3) @(posedge clk);
            #1 rt_rst = 1'b0;
            @(posedge clk); #1;
            for (int j = 0; j < 16; j++) begin
                for (int k = 0; k < 16; k++) begin
                    blk[127-8*k -: 8] = sbox_fwd(8'(16*j + k));
                    exp[127-8*k -: 8] = 8'(16*j + k);
                end
                iv  = 1'b1;
                si  = blk;
                acc = 1'b0;
                for (int t = 0; t < 50 && !acc; t++) begin
                    acc = ir;
                    @(posedge clk); #1;
                end
                iv  = 1'b0;
                lat = 1;
                while (!ov && lat < 50) begin
                    @(posedge clk); #1;
                    lat++;
                end
                chk($sformatf("rt_bpc%0d_lat%0d", P, j), 128'(lat), 128'(N + 1));
                chk($sformatf("rt_bpc%0d_blk%0d", P, j), so, exp);
                @(posedge clk); #1;
            end
            done = 1'b1;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        state_in  = '0;
        for (int x = 0; x < 256; x++) inv_tab[sbox_fwd(8'(x))] = 8'(x);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_vr", {126'b0, out_valid, in_ready}, 128'b00);
        chk("reset_data", state_out, 128'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_release_vr", {126'b0, out_valid, in_ready}, 128'b01);

        run_blk({16{8'h63}}, 128'h0, "all63");
        run_blk({4{32'h637c1600}}, {4{32'h0001ff52}}, "vec637c");

        for (int i = 0; i < 12; i++) begin
            logic [127:0] r;
            r = rand_blk();
            run_blk(r, inv_state(r), $sformatf("rand%0d", i));
        end

        run_backpressure();
        run_reset_mid();
        run_stream();

        for (int t = 0; t < 5000 && !(g_rt[0].done && g_rt[1].done && g_rt[2].done
                                       && g_rt[3].done && g_rt[4].done); t++)
            @(posedge clk);
        chk("rt_all_done",
            128'({g_rt[4].done, g_rt[3].done, g_rt[2].done, g_rt[1].done, g_rt[0].done}),
            128'h1f);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
